// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC holder and instruction-memory fetch stage feeding decode
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] target;
    logic        drain_fault;
    logic        redir_ok;
    logic        redir_bad;
    logic        busy_no_ack;

    assign redir_ok    = redirect && (state != FAULT) && (redirect_pc[1:0] == 2'b00);
    assign redir_bad   = redirect && (state != FAULT) && (redirect_pc[1:0] != 2'b00);
    assign busy_no_ack = ((state == REQ) || (state == DRAIN)) && !imem_ack;
    assign imem_addr   = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = redir_bad ? FAULT : REQ;
            REQ: begin
                if (redir_ok)       state_next = imem_ack ? REQ : DRAIN;
                else if (redir_bad) state_next = imem_ack ? FAULT : DRAIN;
                else if (imem_ack)  state_next = HOLD;
            end
            HOLD: begin
                if (redir_ok)         state_next = REQ;
                else if (redir_bad)   state_next = FAULT;
                else if (instr_ready) state_next = REQ;
            end
            DRAIN: begin
                // A fault recorded while draining wins once the stale response lands.
                if (redir_bad)     state_next = imem_ack ? FAULT : DRAIN;
                else if (imem_ack) state_next = drain_fault ? FAULT : REQ;
            end
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == REQ) || (state == DRAIN);
    end

    // The outstanding address must not move, so a redirect that arrives before
    // the ack is parked in target and loaded into pc when the drain completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            target      <= RESET_PC;
            instruction <= NOP_INSTR;
            instr_pc    <= 32'h0000_0000;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            drain_fault <= 1'b0;
        end else if (redir_ok) begin
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
            if (busy_no_ack) begin
                target <= redirect_pc;
            end else begin
                pc <= redirect_pc;
            end
        end else if (redir_bad) begin
            fetch_fault <= 1'b1;
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
            if (busy_no_ack) begin
                drain_fault <= 1'b1;
            end
        end else begin
            case (state)
                REQ: begin
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        instruction <= NOP_INSTR;
                    end
                end
                DRAIN: begin
                    if (imem_ack && !drain_fault) begin
                        pc <= target;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - table-driven cycle vectors for instruction_fetch
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int compared   = 0;
    int mismatched = 0;

    instruction_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return 32'hA000_0000 | a;
    endfunction

    // Expected outputs describe the cycle being entered; inputs are then driven for it.
    function automatic vec_t mk(input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_ipc, input logic e_fault, input logic r,
                                input logic a, input logic rd, input logic rdir, input logic [31:0] rpc);
        vec_t v;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_ipc = e_ipc; v.e_fault = e_fault;
        v.rst = r; v.ack = a; v.rdy = rd; v.redir = rdir; v.rpc = rpc;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s [vec %0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   -1, {31'd0, imem_req},    32'd0);
        chk({tag, "_addr"},  -1, imem_addr,            32'd0);
        chk({tag, "_valid"}, -1, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, -1, instruction,          NOP);
        chk({tag, "_ipc"},   -1, instr_pc,             32'd0);
        chk({tag, "_fault"}, -1, {31'd0, fetch_fault}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;

        //        req addr           v  ipc           f  rst ack rdy rdir rpc
        // stream with zero-wait memory
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,        0, 32'h0,        0, 0, 1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h4,        1, 32'h0,        0, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h4,        0, 32'h0,        0, 0, 1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h8,        1, 32'h4,        0, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h8,        0, 32'h0,        0, 0, 1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 32'hC,        1, 32'h8,        0, 1, 0, 0, 0, 32'h0));
        // stall, drain redirect, hold redirect, wrap, misaligned from REQ
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,        0, 32'h0,        0, 0, 1, 0, 0, 32'h0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 32'h4,    1, 32'h0,        0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h4,        1, 32'h0,        0, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h4,        0, 32'h0,        0, 0, 1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h8,        1, 32'h4,        0, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h8,        0, 32'h0,        0, 0, 0, 0, 1, 32'h100));
        vecs.push_back(mk(1, 32'h8,        0, 32'h0,        0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h8,        0, 32'h0,        0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h8,        0, 32'h0,        0, 0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h100,      0, 32'h0,        0, 0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h104,      1, 32'h100,      0, 0, 0, 1, 1, 32'h40));
        vecs.push_back(mk(1, 32'h40,       0, 32'h0,        0, 0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h44,       1, 32'h40,       0, 0, 0, 0, 1, 32'hFFFF_FFFC));
        vecs.push_back(mk(1, 32'hFFFF_FFFC,0, 32'h0,        0, 0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0,        1, 32'hFFFF_FFFC,0, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,        0, 32'h0,        0, 0, 1, 0, 1, 32'h200));
        vecs.push_back(mk(1, 32'h200,      0, 32'h0,        0, 0, 0, 0, 1, 32'h102));
        vecs.push_back(mk(1, 32'h200,      0, 32'h0,        1, 0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h200,      0, 32'h0,        1, 0, 1, 1, 1, 32'h300));
        vecs.push_back(mk(0, 32'h200,      0, 32'h0,        1, 1, 0, 0, 0, 32'h0));
        // ack in IDLE ignored, misaligned redirect from HOLD, later redirect ignored
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,        0, 32'h0,        0, 0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h4,        1, 32'h0,        0, 0, 0, 1, 1, 32'h102));
        vecs.push_back(mk(0, 32'h4,        0, 32'h0,        1, 0, 0, 0, 1, 32'h40));
        vecs.push_back(mk(0, 32'h4,        0, 32'h0,        1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h4,        0, 32'h0,        1, 1, 0, 0, 0, 32'h0));
        // enter DRAIN with a misaligned redirect
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,        0, 32'h0,        0, 0, 0, 0, 1, 32'h102));

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        foreach (vecs[i]) begin
            chk("imem_req",    i, {31'd0, imem_req},    {31'd0, vecs[i].e_req});
            chk("imem_addr",   i, imem_addr,            vecs[i].e_addr);
            chk("instr_valid", i, {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
            chk("instruction", i, instruction,          vecs[i].e_valid ? mem(vecs[i].e_ipc) : NOP);
            chk("fetch_fault", i, {31'd0, fetch_fault}, {31'd0, vecs[i].e_fault});
            if (vecs[i].e_valid)
                chk("instr_pc", i, instr_pc, vecs[i].e_ipc);
            rst         = vecs[i].rst;
            imem_ack    = vecs[i].ack;
            imem_rdata  = vecs[i].ack ? mem(imem_addr) : 32'hDEAD_BEEF;
            instr_ready = vecs[i].rdy;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            @(negedge clk);
        end

        // Now in DRAIN with a fault recorded; async reset must clear it mid-cycle.
        imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        chk("drain_req",   -1, {31'd0, imem_req},    32'd1);
        chk("drain_fault", -1, {31'd0, fetch_fault}, 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async");
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of the instruction decode/parse stage. Holds the PC and issues word reads to instruction memory over a req/ack handshake. Presents each fetched 32-bit instruction and its PC to decode over a valid/ready handshake. Accepts redirects (branch, JAL, JALR targets) from execute and squashes any stale fetch in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
NOP_INSTR, 32'h0000_0013, value driven on instruction whenever nothing valid is held (ADDI x0,x0,0).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
imem_req  output  1  read request, level; held until imem_ack.
imem_addr  output  32  read address; stable while imem_req=1.
imem_ack  input  1  one-cycle pulse completing the current request; may coincide with the first imem_req cycle.
imem_rdata  input  32  read data, valid only in the imem_ack cycle.
instruction  output  32  fetched instruction to decode.
instr_pc  output  32  PC of instruction.
instr_valid  output  1  instruction/instr_pc valid.
instr_ready  input  1  decode accepts; transfer when instr_valid & instr_ready.
redirect  input  1  one-cycle pulse: change PC to redirect_pc.
redirect_pc  input  32  redirect target.
fetch_fault  output  1  sticky; set when a redirect target is misaligned.

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instruction=NOP_INSTR, instr_pc=0, instr_valid=0, fetch_fault=0, drain_fault=0.
- imem_addr is always the pc register. imem_req=1 exactly in states REQ and DRAIN.
- States:
  - IDLE: next cycle goes to REQ. This is the single cycle after reset deasserts.
  - REQ: imem_req=1. On imem_ack: instruction<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^32, wraps from 32'hFFFF_FFFC to 0), then HOLD.
  - HOLD: instr_valid=1. instruction and instr_pc must stay stable until accepted. On instr_ready: instr_valid<=0, instruction<=NOP_INSTR, then REQ. Peak throughput is one instruction every 2 cycles with zero-wait memory.
  - DRAIN: imem_req=1 with the old address. The response is discarded. On imem_ack: go to FAULT if drain_fault is set, else REQ.
  - FAULT: imem_req=0, instr_valid=0. Stays here until reset; redirect is ignored.
- Redirect has priority over every other event in the same cycle. Aligned means redirect_pc[1:0]==0.
  - Aligned redirect: pc<=redirect_pc, instr_valid<=0, instruction<=NOP_INSTR.
  - From REQ without imem_ack: go to DRAIN; the request is never withdrawn before ack.
  - From REQ with imem_ack in the same cycle: discard imem_rdata and go to REQ.
  - From HOLD (with or without instr_ready): go to REQ; the held instruction is squashed.
  - From IDLE: go to REQ.
  - From DRAIN: retarget pc, stay in DRAIN. If imem_ack arrives in the same cycle, go to REQ.
  - Misaligned redirect: fetch_fault<=1, instr_valid<=0, pc unchanged.
    - From REQ without ack: go to DRAIN and set drain_fault.
    - From DRAIN without ack: stay in DRAIN and set drain_fault.
    - Otherwise: go to FAULT.
- An imem_ack outside REQ or DRAIN is ignored.
- Reset mid-transaction returns to IDLE immediately. Memory must drop any pending ack on reset.

Test Plan:
- Reset release, RESET_PC=0, memory ack in the same cycle as req, instr_ready=1 -> imem_addr sequence 0,4,8. instr_valid pulses every 2nd cycle with instr_pc 0,4,8 and the matching rdata.
- instr_ready=0 for 5 cycles after a fetch returning 32'h00500093 -> instruction/instr_pc stay at 32'h00500093/0 with instr_valid=1. No new imem_req until ready rises.
- Redirect to 32'h100 while REQ at pc 8 is waiting (ack 3 cycles later) -> imem_addr stays 8 until ack, that data is dropped, next request is at 32'h100, and the first valid instr_pc is 32'h100.
- Redirect to 32'h40 in HOLD with instr_ready=1 in the same cycle -> instr_valid=0 next cycle, next request is at 32'h40.
- Redirect to 32'h102 -> fetch_fault=1, imem_req stays 0, instr_valid stays 0 until rst. A later aligned redirect has no effect.
- Redirect to 32'hFFFF_FFFC, then fetch -> next imem_addr is 0 (wrap).
- Assert rst while in DRAIN -> all outputs return to reset values immediately.
